// File: rtl/point_source_arbiter.sv
// Round-robin source arbiter that feeds the point cloud assembler one 4-point group at a time.
// Groups that end early, or whose source stalls too long, are finished with zero pad points.
module point_source_arbiter #(
    parameter int N_SRC   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC*128-1:0]       src_data,
    input  logic [N_SRC-1:0]           src_last,
    output logic [N_SRC-1:0]           src_ready,
    input  logic                       asm_busy,
    output logic [31:0]                pt_x,
    output logic [31:0]                pt_y,
    output logic [31:0]                pt_z,
    output logic [7:0]                 pt_R,
    output logic [7:0]                 pt_G,
    output logic [7:0]                 pt_B,
    output logic [7:0]                 pt_intensity,
    output logic                       pt_valid,
    output logic                       pt_pad,
    output logic [$clog2(N_SRC)-1:0]   grp_src,
    output logic                       grp_done,
    output logic [15:0]                pad_count
);

    localparam int          OW        = $clog2(N_SRC);
    localparam logic [OW:0] N_C       = (OW+1)'(N_SRC);
    localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_PAD} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic [1:0]      slot_cnt_q, slot_cnt_d;
    logic [7:0]      idle_cnt_q, idle_cnt_d;
    logic [15:0]     pad_count_q, pad_count_d;
    logic [127:0]    pt_data_q, pt_data_d;
    logic            pt_valid_q, pt_valid_d;
    logic            pt_pad_q, pt_pad_d;
    logic            grp_done_q, grp_done_d;

    logic            sel_valid;
    logic            sel_last;
    logic [127:0]    sel_data;
    logic            any_req;
    logic [OW-1:0]   grant_idx;
    logic [OW:0]     arb_cand;
    logic            accept;
    logic            stall_tick;
    logic            issue_pad;
    logic [7:0]      idle_inc;
    logic            timeout_hit;

    // Owner's channel, picked by comparison so no variable part-select is needed.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (owner_q == OW'(i)) begin
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
                sel_data  = src_data[128*i +: 128];
            end
        end
    end

    // Scan from farthest to nearest so the source right after last_owner wins.
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        arb_cand  = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            arb_cand = {1'b0, last_owner_q} + (OW+1)'(k);
            if (arb_cand >= N_C) arb_cand = arb_cand - N_C;
            if (src_valid[arb_cand[OW-1:0]]) begin
                any_req   = 1'b1;
                grant_idx = arb_cand[OW-1:0];
            end
        end
    end

    // FSM output process: handshake and issue strobes.
    always_comb begin
        src_ready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_ready[i] = (state_q == S_STREAM) && (owner_q == OW'(i)) && !asm_busy;
        end
        accept      = (state_q == S_STREAM) && sel_valid && !asm_busy;
        stall_tick  = (state_q == S_STREAM) && !sel_valid && !asm_busy;
        issue_pad   = (state_q == S_PAD) && !asm_busy;
        idle_inc    = idle_cnt_q + 8'd1;
        timeout_hit = stall_tick && (idle_inc == TIMEOUT_C);
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        slot_cnt_d   = slot_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        pad_count_d  = pad_count_q;
        pt_data_d    = pt_data_q;
        pt_valid_d   = 1'b0;
        pt_pad_d     = 1'b0;
        grp_done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (any_req && !asm_busy) begin
                    owner_d    = grant_idx;
                    slot_cnt_d = 2'd0;
                    idle_cnt_d = 8'd0;
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                if (accept) begin
                    pt_data_d  = sel_data;
                    pt_valid_d = 1'b1;
                    slot_cnt_d = slot_cnt_q + 2'd1;
                    idle_cnt_d = 8'd0;
                    if (slot_cnt_q == 2'd3) begin
                        grp_done_d   = 1'b1;
                        last_owner_d = owner_q;
                        state_d      = S_IDLE;
                    end else if (sel_last) begin
                        state_d = S_PAD;
                    end
                end else if (stall_tick) begin
                    idle_cnt_d = idle_inc;
                    if (timeout_hit) begin
                        if (slot_cnt_q != 2'd0) begin
                            state_d = S_PAD;
                        end else begin
                            last_owner_d = owner_q;
                            state_d      = S_IDLE;
                        end
                    end
                end
            end
            S_PAD: begin
                if (issue_pad) begin
                    pt_data_d  = '0;
                    pt_valid_d = 1'b1;
                    pt_pad_d   = 1'b1;
                    slot_cnt_d = slot_cnt_q + 2'd1;
                    if (pad_count_q != 16'hFFFF) pad_count_d = pad_count_q + 16'd1;
                    if (slot_cnt_q == 2'd3) begin
                        grp_done_d   = 1'b1;
                        last_owner_d = owner_q;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(N_SRC - 1);
            slot_cnt_q   <= 2'd0;
            idle_cnt_q   <= 8'd0;
            pad_count_q  <= 16'd0;
            pt_data_q    <= '0;
            pt_valid_q   <= 1'b0;
            pt_pad_q     <= 1'b0;
            grp_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            slot_cnt_q   <= slot_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            pad_count_q  <= pad_count_d;
            pt_data_q    <= pt_data_d;
            pt_valid_q   <= pt_valid_d;
            pt_pad_q     <= pt_pad_d;
            grp_done_q   <= grp_done_d;
        end
    end

    assign pt_x         = pt_data_q[127:96];
    assign pt_y         = pt_data_q[95:64];
    assign pt_z         = pt_data_q[63:32];
    assign pt_R         = pt_data_q[31:24];
    assign pt_G         = pt_data_q[23:16];
    assign pt_B         = pt_data_q[15:8];
    assign pt_intensity = pt_data_q[7:0];
    assign pt_valid     = pt_valid_q;
    assign pt_pad       = pt_pad_q;
    assign grp_done     = grp_done_q;
    assign grp_src      = owner_q;
    assign pad_count    = pad_count_q;

endmodule

// File: tb/tb_point_source_arbiter.sv
// Randomised bench for point_source_arbiter: a group-level reference model predicts every
// output point with its cycle stamp, and a monitor compares what the arbiter issues.
module tb_point_source_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk;
    logic           reset;
    logic [N-1:0]   src_valid;
    logic [N*128-1:0] src_data;
    logic [N-1:0]   src_last;
    logic [N-1:0]   src_ready;
    logic           asm_busy;
    logic [31:0]    pt_x, pt_y, pt_z;
    logic [7:0]     pt_R, pt_G, pt_B, pt_intensity;
    logic           pt_valid, pt_pad, grp_done;
    logic [1:0]     grp_src;
    logic [15:0]    pad_count;

    point_source_arbiter #(.N_SRC(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready), .asm_busy(asm_busy),
        .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
        .pt_R(pt_R), .pt_G(pt_G), .pt_B(pt_B), .pt_intensity(pt_intensity),
        .pt_valid(pt_valid), .pt_pad(pt_pad), .grp_src(grp_src),
        .grp_done(grp_done), .pad_count(pad_count)
    );

    typedef struct {
        logic [127:0] data;
        logic         pad;
        int           src;
        logic         done;
        int           padc;
        int           stamp;
    } exp_t;

    typedef enum {M_IDLE, M_STREAM, M_PAD} mode_e;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;

    // Reference model: who owns the grant, how many points the group has, how long it has waited.
    mode_e m_mode;
    int    m_owner, m_last, m_cnt, m_idle, m_pad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_owner = 0;
        m_last  = N - 1;
        m_cnt   = 0;
        m_idle  = 0;
        m_pad   = 0;
        exp_q.delete();
    endtask

    task automatic push_point(input logic [127:0] data, input logic pad);
        exp_t e;
        e.data  = data;
        e.pad   = pad;
        e.src   = m_owner;
        e.done  = (m_cnt == 3);
        e.padc  = m_pad;
        e.stamp = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Called with the inputs for this cycle settled; predicts the effect of the coming edge.
    task automatic model_step();
        logic [N-1:0] exp_rdy;
        exp_rdy = (m_mode == M_STREAM && !asm_busy) ? N'(1 << m_owner) : '0;
        check("src_ready", 128'(src_ready), 128'(exp_rdy));
        if (asm_busy) return;
        case (m_mode)
            M_IDLE: begin
                for (int j = 1; j <= N; j++) begin
                    int s;
                    s = (m_last + j) % N;
                    if (src_valid[s]) begin
                        m_owner = s;
                        m_cnt   = 0;
                        m_idle  = 0;
                        m_mode  = M_STREAM;
                        break;
                    end
                end
            end
            M_STREAM: begin
                if (src_valid[m_owner]) begin
                    push_point(src_data[128*m_owner +: 128], 1'b0);
                    m_cnt++;
                    m_idle = 0;
                    if (m_cnt == 4) begin
                        m_last = m_owner;
                        m_mode = M_IDLE;
                    end else if (src_last[m_owner]) begin
                        m_mode = M_PAD;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TO) begin
                        if (m_cnt > 0) m_mode = M_PAD;
                        else begin
                            m_last = m_owner;
                            m_mode = M_IDLE;
                        end
                    end
                end
            end
            M_PAD: begin
                m_pad = (m_pad < 65535) ? m_pad + 1 : 65535;
                push_point('0, 1'b1);
                m_cnt++;
                if (m_cnt == 4) begin
                    m_last = m_owner;
                    m_mode = M_IDLE;
                end
            end
            default: ;
        endcase
    endtask

    task automatic drive_random(input int vpct, input int bpct, input int lpct);
        for (int i = 0; i < N; i++) begin
            src_valid[i]            = ($urandom_range(99) < vpct);
            src_last[i]             = ($urandom_range(99) < lpct);
            src_data[128*i +: 128]  = {$urandom, $urandom, $urandom, $urandom};
        end
        asm_busy = ($urandom_range(99) < bpct);
    endtask

    // Entered at a falling edge, leaves at the next one.
    task automatic step(input int vpct, input int bpct, input int lpct);
        drive_random(vpct, bpct, lpct);
        #1;
        model_step();
        @(negedge clk);
    endtask

    task automatic run_phase(input int vpct, input int bpct, input int lpct, input int n);
        for (int c = 0; c < n; c++) step(vpct, bpct, lpct);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_pt_data"}, {pt_x, pt_y, pt_z, pt_R, pt_G, pt_B, pt_intensity}, '0);
        check({tag, "_pt_valid"}, 128'(pt_valid), '0);
        check({tag, "_pt_pad"}, 128'(pt_pad), '0);
        check({tag, "_grp_done"}, 128'(grp_done), '0);
        check({tag, "_grp_src"}, 128'(grp_src), '0);
        check({tag, "_pad_count"}, 128'(pad_count), '0);
        check({tag, "_src_ready"}, 128'(src_ready), '0);
    endtask

    // Monitor: every issued point must match the oldest prediction, in the predicted cycle.
    always @(negedge clk) begin
        if (pt_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pt_valid", 128'(1), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("pt_cycle", 128'(cyc), 128'(mon_e.stamp));
                check("pt_data", {pt_x, pt_y, pt_z, pt_R, pt_G, pt_B, pt_intensity}, mon_e.data);
                check("pt_pad", 128'(pt_pad), 128'(mon_e.pad));
                check("grp_src", 128'(grp_src), 128'(mon_e.src));
                check("grp_done", 128'(grp_done), 128'(mon_e.done));
                check("pad_count", 128'(pad_count), 128'(mon_e.padc));
            end
        end else if (grp_done) begin
            check("grp_done_without_pt", 128'(1), 128'(0));
        end
    end

    initial begin
        bit hit_pad;
        reset     = 1'b1;
        src_valid = '1;
        src_last  = '0;
        src_data  = '0;
        asm_busy  = 1'b0;
        #1 reset  = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");

        src_valid = '0;
        model_reset();
        reset = 1'b1;

        run_phase(100, 0, 0, 60);     // back-to-back groups, pure round robin
        run_phase(70, 20, 10, 400);   // mixed traffic with backpressure and early ends
        run_phase(5, 10, 20, 600);    // sparse sources: timeouts with and without points
        run_phase(100, 30, 30, 300);  // heavy backpressure and frequent early last

        hit_pad = 1'b0;
        for (int c = 0; c < 500 && !hit_pad; c++) begin
            step(100, 0, 50);
            hit_pad = (m_mode == M_PAD);
        end
        check("reached_pad_state", 128'(hit_pad), 128'(1));
        #2 reset = 1'b0;
        exp_q.delete();
        #1 check_cleared("async_reset");
        src_valid = '1;
        asm_busy  = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_held_in_reset", 128'(src_ready), '0);
        model_reset();
        reset = 1'b1;
        step(100, 0, 0);
        check("first_grant_after_reset", 128'(src_ready), 128'(4'b0001));

        run_phase(80, 15, 10, 300);
        run_phase(0, 0, 0, 60);       // let any open group drain through timeout/pad
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/point_source_arbiter.md
# point_source_arbiter

Round-robin arbiter and group sequencer in front of the point cloud assembler. It shares the assembler's single point input between N_SRC LiDAR return channels. It grants one source per 4-point group, so every 512-bit packed word holds points from exactly one source. Short groups (source end-of-scan, or a source stall past a timeout) are completed with zero pad points, which keeps the downstream 4-point packing aligned.

## Interface

Parameters:
- N_SRC, 4: number of requesting sources (2..8).
- TIMEOUT, 16: idle cycles allowed mid-group before padding (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- src_valid  in  N_SRC  per-source point valid.
- src_data  in  N_SRC*128  per-source point; slice i is bits [128*i+127:128*i]. Within a slice: [127:96] x, [95:64] y, [63:32] z, [31:24] R, [23:16] G, [15:8] B, [7:0] intensity.
- src_last  in  N_SRC  marks the final point of the source's scan; qualified by the accept.
- src_ready  out  N_SRC  per-source accept, combinational.
- asm_busy  in  1  downstream stall; while high, no point is accepted or issued.
- pt_x, pt_y, pt_z  out  32 each  to assembler x/y/z.
- pt_R, pt_G, pt_B, pt_intensity  out  8 each  to assembler colour/intensity.
- pt_valid  out  1  to assembler valid_in; single-cycle pulse per point.
- pt_pad  out  1  high with pt_valid when the point is padding.
- grp_src  out  clog2(N_SRC)  owner of the current/last group.
- grp_done  out  1  pulse coinciding with the 4th pt_valid of a group.
- pad_count  out  16  total pad points issued; saturates at 0xFFFF.

## Operation

- States: IDLE, STREAM, PAD. slot_cnt (0..3) counts points issued in the current group.
- **IDLE.** If any src_valid is set, grant the first set bit searching from (last_owner+1) mod N_SRC upward with wrap. Latch owner, set grp_src to owner, clear slot_cnt and idle_cnt, then go to STREAM. If no src_valid is set, stay in IDLE.
- **Accept handshake.** src_ready[i] = (state==STREAM) && (owner==i) && !asm_busy. All other ready bits are 0. An accept is src_valid[owner] && src_ready[owner].
- **Accept effects.** The point is registered onto the pt_* outputs with pt_valid=1 and pt_pad=0. slot_cnt increments and idle_cnt clears.
- **STREAM transitions on accept:**
  - Accept with slot_cnt==3: grp_done, last_owner<=owner, go to IDLE. src_last on this point needs no padding.
  - Accept with src_last=1 and slot_cnt<3: go to PAD.
- **Idle counting.** In STREAM, each cycle with !asm_busy and !src_valid[owner] increments idle_cnt. When idle_cnt reaches TIMEOUT:
  - if slot_cnt>0, go to PAD;
  - if slot_cnt==0, go to IDLE with last_owner<=owner and no grp_done.
- **PAD.** Each cycle with !asm_busy issues one all-zero point with pt_valid=1 and pt_pad=1, increments slot_cnt and increments pad_count (saturating). The 4th point asserts grp_done, sets last_owner<=owner and returns to IDLE.
- **asm_busy.** Freezes the state, slot_cnt and idle_cnt, and suppresses pt_valid. The pt_* data outputs hold their last value.
- **Fairness.** No source can hold the grant for more than one group while another source is requesting.

## Timing

- **Reset values.** While reset is low, all of the following are 0: pt_* data, pt_valid, pt_pad, grp_done, grp_src, pad_count, src_ready. state=IDLE, slot_cnt=0, idle_cnt=0, last_owner=N_SRC-1, so source 0 wins the first arbitration.
- **Mid-group reset.** Reset asserted mid-group abandons the group with no pad and no grp_done. The downstream is reset with the same signal.
- **Grant latency.** Request seen in IDLE at cycle t gives STREAM at t+1. The earliest accept is at t+1.
- **Data latency.** Accept at cycle t gives pt_valid at t+1. grp_done is asserted in the same cycle as the group's 4th pt_valid.
- **Throughput.** 4 points per 5 cycles per back-to-back group, because of the 1 arbitration cycle.
- **Pad points.** PAD issues one pad point per unstalled cycle. Pad output is registered exactly like real points.
- **Simultaneous events.** asm_busy high in the same cycle as src_valid means no accept. src_last together with timeout cannot occur, because a valid point resets idle_cnt.
- **Stable signals.** grp_src is stable from grant until the next grant.

## Test plan

- **Single source, 8 points, no stall.** src_valid[2] constant. Expect 2 groups: grp_src=2, grp_done on the 4th and 8th pt_valid, pt_pad never set. pt_x equals src_data x in order, each 1 cycle after its accept.
- **Round-robin.** All 4 sources continuously valid. Expect group owners in the order 0,1,2,3,0. Each group is exactly 4 points, with a 1-cycle gap between groups.
- **Early last.** src_last on the 2nd point of source 1. Expect 2 real points, then 2 pad points (all-zero, pt_pad=1) on consecutive cycles. grp_done is on the 2nd pad and pad_count=2.
- **Timeout.** TIMEOUT=16, source 3 sends 3 points then drops valid. Exactly 16 idle cycles later, 1 pad point and grp_done are issued, and pad_count increments by 1. Repeat with source 3 going idle before its first point: it returns to IDLE with no pt_valid.
- **Backpressure.** asm_busy held high for 5 cycles mid-group. src_ready stays 0 and pt_valid stays 0. idle_cnt does not advance, so no timeout occurs. The group completes normally after release.
- **Async reset mid-PAD.** Assert reset low asynchronously in the middle of PAD. All outputs are 0 immediately. After release, source 0 is granted first.
